// File: rtl/pb_debounce.sv
// Push-button debounce front end: 2-flop synchroniser, slowref prescaler and one
// REL/PRS qualification FSM per button. Define PB_STUCK_DETECT_EN to add stuck-button detection.
module pb_debounce #(
  parameter int CLK_DIV     = 50000,
  parameter int STABLE_CNT  = 4,
  parameter int NB          = 4,
  parameter int STUCK_TICKS = 1000
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic [NB-1:0] pb_raw,
  output logic          slowref,
  output logic [NB-1:0] clean,
  output logic [NB-1:0] stuck
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (CLK_DIV < 2 || STABLE_CNT < 1 || NB < 1 || STUCK_TICKS < 1) begin : g_param_check
    $error("pb_debounce: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_REL      = 3'd0,
    S_REL_PEND = 3'd1,
    S_PRS      = 3'd2,
    S_PRS_PEND = 3'd3
`ifdef PB_STUCK_DETECT_EN
    , S_STUCK  = 3'd4
`endif
  } state_e;

  logic [NB-1:0]    sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             slowref_q, slowref_d;
  state_e           state_q [NB];
  state_e           state_d [NB];
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [NB-1:0]    clean_q, clean_d;

`ifdef PB_STUCK_DETECT_EN
  localparam int STK_W = $clog2(STUCK_TICKS + 1);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_TICKS - 1);
  localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);
  logic [STK_W-1:0] stk_q [NB];
  logic [STK_W-1:0] stk_d [NB];
  logic [NB-1:0]    stuck_q, stuck_d;
`endif

  // Prescaler: slowref is registered, so it is high the cycle after div_q hits the last count
  always_comb begin
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
    slowref_d = (div_q == DIV_LAST);
  end

  always_ff @(posedge clk or negedge resetb) begin : state_reg
    if (!resetb) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      div_q     <= '0;
      slowref_q <= 1'b0;
      clean_q   <= '1;
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= S_REL;
        cnt_q[i]   <= '0;
`ifdef PB_STUCK_DETECT_EN
        stk_q[i]   <= '0;
`endif
      end
`ifdef PB_STUCK_DETECT_EN
      stuck_q   <= '0;
`endif
    end else begin
      sync1_q   <= pb_raw;
      sync2_q   <= sync1_q;
      div_q     <= div_d;
      slowref_q <= slowref_d;
      clean_q   <= clean_d;
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef PB_STUCK_DETECT_EN
        stk_q[i]   <= stk_d[i];
`endif
      end
`ifdef PB_STUCK_DETECT_EN
      stuck_q   <= stuck_d;
`endif
    end
  end

  // In REL/PRS the counter is 0, so the CNT_LAST test there only fires when STABLE_CNT==1
  always_comb begin : next_state
    for (int i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef PB_STUCK_DETECT_EN
      stk_d[i]   = stk_q[i];
`endif
      if (slowref_q) begin
        unique case (state_q[i])
          S_REL: begin
            if (!sync2_q[i]) begin
              if (cnt_q[i] == CNT_LAST) begin
                state_d[i] = S_PRS;
                cnt_d[i]   = '0;
              end else begin
                state_d[i] = S_REL_PEND;
                cnt_d[i]   = cnt_q[i] + CNT_ONE;
              end
            end
          end
          S_REL_PEND: begin
            if (sync2_q[i]) begin
              state_d[i] = S_REL;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = S_PRS;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CNT_ONE;
            end
          end
          S_PRS: begin
`ifdef PB_STUCK_DETECT_EN
            if (stk_q[i] == STK_LAST) begin
              state_d[i] = S_STUCK;
              cnt_d[i]   = '0;
            end else
`endif
            if (sync2_q[i]) begin
              if (cnt_q[i] == CNT_LAST) begin
                state_d[i] = S_REL;
                cnt_d[i]   = '0;
              end else begin
                state_d[i] = S_PRS_PEND;
                cnt_d[i]   = cnt_q[i] + CNT_ONE;
              end
            end
          end
          S_PRS_PEND: begin
            if (!sync2_q[i]) begin
              state_d[i] = S_PRS;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = S_REL;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CNT_ONE;
            end
          end
`ifdef PB_STUCK_DETECT_EN
          S_STUCK: begin
            if (!sync2_q[i]) begin
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = S_REL;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CNT_ONE;
            end
          end
`endif
          default: begin
            state_d[i] = S_REL;
            cnt_d[i]   = '0;
          end
        endcase
`ifdef PB_STUCK_DETECT_EN
        // Only ticks spent entirely inside PRS count towards the stuck limit
        if (state_q[i] == S_PRS && state_d[i] == S_PRS) stk_d[i] = stk_q[i] + STK_ONE;
        else                                            stk_d[i] = '0;
`endif
      end
    end
  end

  always_comb begin : outputs
    for (int i = 0; i < NB; i++) begin
      clean_d[i] = ~((state_d[i] == S_PRS) || (state_d[i] == S_PRS_PEND));
`ifdef PB_STUCK_DETECT_EN
      stuck_d[i] = (state_d[i] == S_STUCK);
`endif
    end
  end

  assign slowref = slowref_q;
  assign clean   = clean_q;
`ifdef PB_STUCK_DETECT_EN
  assign stuck   = stuck_q;
`else
  assign stuck   = '0;
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboard bench for pb_debounce: stimulus queues expected {clean,stuck} per slowref
// tick; a monitor pops and compares after each tick's update edge.
module tb_pb_debounce;

  localparam int CLK_DIV     = 8;
  localparam int STABLE_CNT  = 4;
  localparam int NB          = 4;
  localparam int STUCK_TICKS = 16;

  logic          clk = 1'b0;
  logic          resetb;
  logic [NB-1:0] pb_raw;
  logic          slowref;
  logic [NB-1:0] clean;
  logic [NB-1:0] stuck;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  logic [7:0] exp_q [$];

  pb_debounce #(
    .CLK_DIV(CLK_DIV), .STABLE_CNT(STABLE_CNT), .NB(NB), .STUCK_TICKS(STUCK_TICKS)
  ) dut (
    .clk(clk), .resetb(resetb), .pb_raw(pb_raw),
    .slowref(slowref), .clean(clean), .stuck(stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: the FSM update happens on the edge that ends the slowref-high cycle
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (slowref) begin
        @(negedge clk);
        tick_no++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("tick%0d_clean_stuck", tick_no), {clean, stuck}, e);
        end
      end
    end
  end

  task automatic step(input logic [3:0] raw, input logic [3:0] ec, input logic [3:0] es);
    int n;
    pb_raw = raw;
    exp_q.push_back({ec, es});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!slowref && n < 3 * CLK_DIV);
    if (!slowref) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout actual=no_slowref required=slowref within %0d cycles", 3 * CLK_DIV);
    end
    @(negedge clk);
  endtask

  task automatic steps(input int cnt, input logic [3:0] raw, input logic [3:0] ec,
                       input logic [3:0] es);
    for (int k = 0; k < cnt; k++) step(raw, ec, es);
  endtask

  initial begin : stimulus
    int n;
    resetb = 1'b0;
    pb_raw = '1;
    repeat (3) @(negedge clk);
    chk("reset_clean", {4'h0, clean}, 8'h0F);
    chk("reset_stuck", {4'h0, stuck}, 8'h00);
    chk("reset_slowref", {7'h0, slowref}, 8'h00);
    resetb = 1'b1;

    // slowref high exactly in cycles 8, 16, 24 after release
    for (int c = 1; c <= 3 * CLK_DIV; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("slowref_cyc%0d", c), {7'h0, slowref}, {7'h0, (c % CLK_DIV) == 0});
    end
    @(negedge clk);
    @(negedge clk);

    // Clean press on button 0
    steps(3, 4'b1110, 4'hF, 4'h0);
    step(4'b1110, 4'hE, 4'h0);
    steps(2, 4'b1110, 4'hE, 4'h0);

    // Bounce on button 1: 3 low, 1 high, then 4 low
    steps(3, 4'b1100, 4'hE, 4'h0);
    step(4'b1110, 4'hE, 4'h0);
    steps(3, 4'b1100, 4'hE, 4'h0);
    step(4'b1100, 4'hC, 4'h0);

    // Simultaneous release of buttons 0 and 1
    steps(3, 4'b1111, 4'hC, 4'h0);
    step(4'b1111, 4'hF, 4'h0);

    // Buttons 0 and 2 press together, button 0 releases with a bounce
    steps(3, 4'b1010, 4'hF, 4'h0);
    step(4'b1010, 4'hA, 4'h0);
    step(4'b1011, 4'hA, 4'h0);
    step(4'b1010, 4'hA, 4'h0);
    steps(3, 4'b1011, 4'hA, 4'h0);
    step(4'b1011, 4'hB, 4'h0);
    steps(3, 4'b1111, 4'hB, 4'h0);
    step(4'b1111, 4'hF, 4'h0);

    // Reset in REL_PEND with cnt=2, then a fresh full qualification
    steps(2, 4'b1101, 4'hF, 4'h0);
    #2 resetb = 1'b0;
    #1;
    chk("midreset_clean", {4'h0, clean}, 8'h0F);
    chk("midreset_stuck", {4'h0, stuck}, 8'h00);
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    steps(3, 4'b1101, 4'hF, 4'h0);
    step(4'b1101, 4'hD, 4'h0);
    steps(3, 4'b1111, 4'hD, 4'h0);
    step(4'b1111, 4'hF, 4'h0);

    // Long press on button 3
    steps(3, 4'b0111, 4'hF, 4'h0);
    step(4'b0111, 4'h7, 4'h0);
`ifdef PB_STUCK_DETECT_EN
    steps(15, 4'b0111, 4'h7, 4'h0);
    step(4'b0111, 4'hF, 4'h8);
    steps(2, 4'b0111, 4'hF, 4'h8);
    steps(3, 4'b1111, 4'hF, 4'h8);
    step(4'b1111, 4'hF, 4'h0);
`else
    steps(18, 4'b0111, 4'h7, 4'h0);
    steps(3, 4'b1111, 4'h7, 4'h0);
    step(4'b1111, 4'hF, 4'h0);
`endif

    n = 0;
    while (exp_q.size() > 0 && n < 4 * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d_pending required=0_pending", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
